// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: converts memory busywaits, load-use
// hazards, taken branches and multi-cycle MUL/DIV into stage hold/bubble/flush controls.
module pipeline_hazard_controller #(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USE_RS1,
    input  logic             ID_USE_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEM_READ,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             EX_MULDIV_START,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    output logic             PC_HOLD,
    output logic             IF_ID_HOLD,
    output logic             ID_EX_HOLD,
    output logic             EX_MEM_HOLD,
    output logic             MEM_WB_HOLD,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             EX_MEM_BUBBLE,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MULDIV     = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

    localparam int MDW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [MDW-1:0]   MD_LOAD   = MDW'(MULDIV_LATENCY - 1);
    // The MULDIV state is left once the count has been decremented down to one.
    localparam logic [MDW-1:0]   MD_LAST   = MDW'(2);
    localparam logic [MDW-1:0]   MD_ONE    = MDW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam state_e           MD_ENTRY  = (MULDIV_LATENCY > 2) ? ST_MULDIV : ST_RUN;

    state_e           state_q, state_d;
    logic [MDW-1:0]   mdcnt_q, mdcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use_s;
    logic pc_hold_s, if_id_hold_s, id_ex_hold_s, ex_mem_hold_s, mem_wb_hold_s;
    logic if_id_flush_s, id_ex_bubble_s, ex_mem_bubble_s;

    // Load-use hazard detect; x0 is hard-wired so it never creates a dependency.
    always_comb begin
        load_use_s = EX_MEM_READ && (EX_RD != 5'd0) &&
                     ((ID_USE_RS1 && (ID_RS1 == EX_RD)) || (ID_USE_RS2 && (ID_RS2 == EX_RD)));
    end

    // Next-state and control outputs, in hazard priority order.
    always_comb begin
        state_d         = state_q;
        mdcnt_d         = mdcnt_q;
        pc_hold_s       = 1'b0;
        if_id_hold_s    = 1'b0;
        id_ex_hold_s    = 1'b0;
        ex_mem_hold_s   = 1'b0;
        mem_wb_hold_s   = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        ex_mem_bubble_s = 1'b0;
        if (!RESET) begin
            state_d = ST_RUN;
            mdcnt_d = {MDW{1'b0}};
        end else if (DMEM_BUSYWAIT) begin
            // Whole pipe frozen; a taken branch in EX stays put and fires afterwards.
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_hold_s  = 1'b1;
            ex_mem_hold_s = 1'b1;
            mem_wb_hold_s = 1'b1;
        end else begin
            case (state_q)
                ST_MULDIV: begin
                    pc_hold_s       = 1'b1;
                    if_id_hold_s    = 1'b1;
                    id_ex_hold_s    = 1'b1;
                    ex_mem_bubble_s = 1'b1;
                    mdcnt_d         = mdcnt_q - MD_ONE;
                    if (mdcnt_q <= MD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_MULDIV;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    if (IMEM_BUSYWAIT) begin
                        pc_hold_s = 1'b1;
                        state_d   = ST_FLUSH_WAIT;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (EX_BRANCH_TAKEN) begin
                        if_id_flush_s  = 1'b1;
                        id_ex_bubble_s = 1'b1;
                        if (IMEM_BUSYWAIT) begin
                            state_d = ST_FLUSH_WAIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (EX_MULDIV_START) begin
                        pc_hold_s       = 1'b1;
                        if_id_hold_s    = 1'b1;
                        id_ex_hold_s    = 1'b1;
                        ex_mem_bubble_s = 1'b1;
                        mdcnt_d         = MD_LOAD;
                        state_d         = MD_ENTRY;
                    end else if (load_use_s || IMEM_BUSYWAIT) begin
                        pc_hold_s      = 1'b1;
                        if_id_hold_s   = 1'b1;
                        id_ex_bubble_s = 1'b1;
                        state_d        = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    mdcnt_d = {MDW{1'b0}};
                end
            endcase
        end
    end

    // Saturating perf counters.
    always_comb begin
        if (pc_hold_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (if_id_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, MUL/DIV countdown and counter registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RUN;
            mdcnt_q     <= {MDW{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mdcnt_q     <= mdcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_HOLD       = pc_hold_s;
    assign IF_ID_HOLD    = if_id_hold_s;
    assign ID_EX_HOLD    = id_ex_hold_s;
    assign EX_MEM_HOLD   = ex_mem_hold_s;
    assign MEM_WB_HOLD   = mem_wb_hold_s;
    assign IF_ID_FLUSH   = if_id_flush_s;
    assign ID_EX_BUBBLE  = id_ex_bubble_s;
    assign EX_MEM_BUBBLE = ex_mem_bubble_s;
    assign STATE         = state_q;
    assign STALL_CNT     = stall_cnt_q;
    assign FLUSH_CNT     = flush_cnt_q;

endmodule
